// File: rtl/ss_sched.sv
// ss_sched: round-robin owner of the single SPI slave-select session, with per-session timeout and guard gap.
// Define SS_SCHED_STAT_EN to add the stat_sess / stat_tmo statistic counters.
module ss_sched #(
  parameter int NREQ  = 4,
  parameter int TMO_W = 8,
  parameter int GUARD = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_mk,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  done,
  input  logic [TMO_W-1:0] tmo_lim,
  output logic [NREQ-1:0]  gnt,
  output logic [2:0]       gnt_id,
  output logic             ss_set,
  output logic             ss_clr,
  output logic [3:0]       l3_id,
  output logic             busy,
  output logic             tmo_evt
`ifdef SS_SCHED_STAT_EN
  ,
  output logic [15:0]      stat_sess,
  output logic [7:0]       stat_tmo
`endif
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;

  typedef enum logic [2:0] {S_IDLE, S_OPEN, S_ACTIVE, S_CLOSE, S_GUARD} state_t;

  state_t           state, state_nxt, idle_or_grd;
  logic [2:0]       ptr, gid_nxt, win_id;
  logic             win_found;
  logic [TMO_W-1:0] tmo_cnt;
  logic [GW-1:0]    grd_cnt;
  logic             cur_req, cur_done, tmo_hit, tmo_close;
  logic [NREQ-1:0]  gnt_nxt;
  logic             ss_set_nxt, ss_clr_nxt, busy_nxt;

  // A zero guard skips the GUARD state entirely.
  assign idle_or_grd = (GUARD > 0) ? S_GUARD : S_IDLE;

  assign cur_req  = req[gnt_id[IW-1:0]];
  assign cur_done = done[gnt_id[IW-1:0]];
  assign tmo_hit  = (tmo_lim != '0) && (tmo_cnt == tmo_lim - TMO_W'(1));

  // Round-robin pick: first set request strictly after the last grantee, wrapping.
  always_comb begin
    logic [IW-1:0] idx;
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IW'((int'(ptr) + i) % NREQ);
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = 3'(idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    tmo_close = 1'b0;
    unique case (state)
      S_IDLE:   if (!clr_mk && win_found) state_nxt = S_OPEN;
      S_OPEN:   state_nxt = clr_mk ? idle_or_grd : S_ACTIVE;
      S_ACTIVE: begin
        // clr_mk aborts silently; done beats a coinciding timeout.
        if (clr_mk)                      state_nxt = idle_or_grd;
        else if (cur_done || !cur_req)   state_nxt = S_CLOSE;
        else if (tmo_hit) begin
          state_nxt = S_CLOSE;
          tmo_close = 1'b1;
        end
      end
      S_CLOSE:  state_nxt = idle_or_grd;
      S_GUARD:  if (int'(grd_cnt) >= GUARD - 1) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign gid_nxt = (state == S_IDLE && state_nxt == S_OPEN) ? win_id : gnt_id;

  always_comb begin
    ss_set_nxt = (state_nxt == S_OPEN);
    ss_clr_nxt = (state_nxt == S_CLOSE);
    busy_nxt   = (state_nxt != S_IDLE);
    gnt_nxt    = '0;
    if (state_nxt == S_OPEN || state_nxt == S_ACTIVE)
      gnt_nxt[gid_nxt[IW-1:0]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      ptr     <= 3'(NREQ - 1);
      tmo_cnt <= '0;
      grd_cnt <= '0;
      gnt     <= '0;
      gnt_id  <= '0;
      ss_set  <= 1'b0;
      ss_clr  <= 1'b0;
      busy    <= 1'b0;
      tmo_evt <= 1'b0;
    end else begin
      state   <= state_nxt;
      gnt_id  <= gid_nxt;
      gnt     <= gnt_nxt;
      ss_set  <= ss_set_nxt;
      ss_clr  <= ss_clr_nxt;
      busy    <= busy_nxt;
      tmo_evt <= tmo_close;
      tmo_cnt <= (state == S_ACTIVE) ? tmo_cnt + TMO_W'(1) : '0;
      grd_cnt <= (state == S_GUARD) ? grd_cnt + GW'(1) : '0;
      // Session over (closed or aborted): the grantee becomes lowest priority.
      if ((state == S_OPEN || state == S_ACTIVE) && state_nxt != S_ACTIVE)
        ptr <= gnt_id;
    end
  end

  assign l3_id = {1'b0, gnt_id};

`ifdef SS_SCHED_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_sess <= '0;
      stat_tmo  <= '0;
    end else if (clr_mk && state == S_IDLE) begin
      stat_sess <= '0;
      stat_tmo  <= '0;
    end else begin
      if (ss_set_nxt && stat_sess != 16'hFFFF) stat_sess <= stat_sess + 16'd1;
      if (tmo_close && stat_tmo != 8'hFF)      stat_tmo  <= stat_tmo + 8'd1;
    end
  end
`endif

endmodule
